// File: rtl/mem_io_pkg.sv
// Shared definitions for the memory/IO responder: IO decode constants, FSM and read-source enums.
// Optional build macro MEM_IO_DROP_CNT_EN adds a dropped-TX-push counter at IO offset 0x8.
package mem_io_pkg;

    localparam logic [1:0]  IO_SEL  = 2'b11;
    localparam logic [15:0] IO_UART = 16'h0000;
    localparam logic [15:0] IO_CNT  = 16'h0004;
    localparam logic [15:0] IO_DROP = 16'h0008;

    typedef enum logic [1:0] {
        RUN,
        PUSH_NUL,
        DRAIN,
        HALTED
    } stop_state_t;

    typedef enum logic [2:0] {
        SRC_RAM,
        SRC_RX,
        SRC_CNT,
        SRC_ZERO,
        SRC_DROP
    } rd_src_t;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_io_tx_fifo.sv
// Synchronous byte FIFO for the UART TX path; simultaneous push and pop are honoured even when full.
module mem_io_tx_fifo #(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          empty,
    output logic          full,
    output logic          drop,
    output logic [CW-1:0] count_next
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Pointers are exactly PW bits wide, so the increment wraps modulo DEPTH for free.
    always_comb begin
        do_pop   = pop & (count_q != '0);
        do_push  = push & ((count_q != FULL_CNT) | do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the reset pointers/count make stale entries unreachable.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign empty      = (count_q == '0);
    assign full       = (count_q == FULL_CNT);
    assign drop       = push & ~do_push;
    assign head       = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign count_next = count_d;

endmodule

// File: rtl/mem_io_responder.sv
// Far-end responder for the CPU byte bus: steers accesses to external RAM or the IO space
// (UART RX/TX, cycle counter, stop sequencer). Build macro MEM_IO_DROP_CNT_EN adds a drop counter.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int RAM_ADDR_W = 17,
    parameter int TX_DEPTH   = 8,
    parameter int CNT_W      = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [31:0]           mem_a,
    input  logic                  mem_wr,
    input  logic [7:0]            mem_wdata,
    output logic [7:0]            mem_rdata,
    output logic                  io_buffer_full,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic                  ram_we,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_pop,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready,
    output logic                  program_stop
);

    localparam int            CW        = $clog2(TX_DEPTH) + 1;
    localparam logic [CW-1:0] NEAR_FULL = CW'(TX_DEPTH - 2);

    logic          io_sel, io_rd, io_wr;
    logic [15:0]   io_off;
    logic          cpu_push, stop_req, fsm_push;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
    logic [7:0]    fifo_din;
    logic [CW-1:0] fifo_count_next;

    stop_state_t      state_q, state_d;
    rd_src_t          rd_src_q, rd_src_d;
    logic [1:0]       rd_byte_q, rd_byte_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             io_full_q, io_full_d;

    logic unused_bits;
    assign unused_bits = &{1'b0, mem_a[31:18]};

    assign io_sel    = (mem_a[17:16] == IO_SEL);
    assign io_off    = mem_a[15:0];
    assign io_rd     = io_sel & ~mem_wr;
    assign io_wr     = io_sel & mem_wr;
    assign ram_addr  = mem_a[RAM_ADDR_W-1:0];
    assign ram_we    = mem_wr & ~io_sel;
    assign ram_wdata = mem_wdata;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        rd_src_d  = SRC_ZERO;
        rd_byte_d = mem_a[1:0];
        rx_byte_d = rx_byte_q;
        snap_d    = snap_q;
        rx_pop    = 1'b0;
        if (!mem_wr && !io_sel) begin
            rd_src_d = SRC_RAM;
        end else if (io_rd && io_off == IO_UART) begin
            if (rx_valid) begin
                rx_pop    = 1'b1;
                rx_byte_d = rx_data;
                rd_src_d  = SRC_RX;
            end
        end else if (io_rd && io_off[15:2] == IO_CNT[15:2]) begin
            rd_src_d = SRC_CNT;
            // Only the byte-0 read refreshes the snapshot, keeping a 4-byte read coherent.
            if (mem_a[1:0] == 2'b00) begin
                snap_d = cnt_q;
            end
`ifdef MEM_IO_DROP_CNT_EN
        end else if (io_rd && io_off[15:1] == IO_DROP[15:1]) begin
            rd_src_d = SRC_DROP;
`endif
        end
    end

    always_comb begin
        cpu_push  = io_wr & (io_off == IO_UART) & (mem_wdata != 8'h00) & (state_q == RUN);
        stop_req  = io_wr & (io_off == IO_CNT) & (state_q == RUN);
        fifo_push = cpu_push | fsm_push;
        fifo_din  = fsm_push ? 8'h00 : mem_wdata;
        fifo_pop  = tx_valid & tx_ready;
        cnt_d     = (state_q != HALTED) ? cnt_q + 1'b1 : cnt_q;
        io_full_d = (fifo_count_next >= NEAR_FULL);
    end

    mem_io_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .push       (fifo_push),
        .push_data  (fifo_din),
        .pop        (fifo_pop),
        .head       (tx_data),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .drop       (fifo_drop),
        .count_next (fifo_count_next)
    );

    assign tx_valid       = ~fifo_empty;
    assign io_buffer_full = io_full_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_src_q  <= SRC_ZERO;
            rd_byte_q <= '0;
            rx_byte_q <= '0;
            snap_q    <= '0;
            cnt_q     <= '0;
            io_full_q <= 1'b0;
        end else begin
            rd_src_q  <= rd_src_d;
            rd_byte_q <= rd_byte_d;
            rx_byte_q <= rx_byte_d;
            snap_q    <= snap_d;
            cnt_q     <= cnt_d;
            io_full_q <= io_full_d;
        end
    end

`ifdef MEM_IO_DROP_CNT_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = (fifo_drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = fifo_drop;
`endif

    always_comb begin
        case (rd_src_q)
            SRC_RAM:  mem_rdata = ram_rdata;
            SRC_RX:   mem_rdata = rx_byte_q;
            SRC_CNT:  mem_rdata = byte_sel(32'(snap_q), rd_byte_q);
`ifdef MEM_IO_DROP_CNT_EN
            SRC_DROP: mem_rdata = rd_byte_q[0] ? drop_q[15:8] : drop_q[7:0];
`endif
            default:  mem_rdata = 8'h00;
        endcase
    end

    // Stop sequencer: state register, next-state logic, outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (stop_req)    state_d = PUSH_NUL;
            PUSH_NUL: if (!fifo_full)  state_d = DRAIN;
            DRAIN:    if (fifo_empty)  state_d = HALTED;
            HALTED:   state_d = HALTED;
            default:  state_d = RUN;
        endcase
    end

    always_comb begin
        fsm_push     = (state_q == PUSH_NUL) & ~fifo_full;
        program_stop = (state_q == HALTED);
    end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory/IO responder that sits on the far end of the CPU byte bus: it consumes `mem_a`, `mem_wr` and CPU write data, and returns read data plus `io_buffer_full`.
- Steers each access either to the 128KB RAM (external synchronous RAM, 1-cycle read latency) or to the IO space, where `mem_a[17:16]==2'b11`.
- IO space contains:
  - UART RX pop port.
  - UART TX FIFO.
  - Free-running cycle counter.
  - Program-stop sequencer.

Parameters:
- RAM_ADDR_W, 17, RAM byte address width (128KB).
- TX_DEPTH, 8, TX FIFO entries; power of two, >=4.
- CNT_W, 32, cycle counter width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; asynchronous, active-low.
- mem_a  input  32  CPU address; only bits 17:0 decoded.
- mem_wr  input  1  1 = write, 0 = read; an access is presented every cycle.
- mem_wdata  input  8  CPU write data (the CPU's mem_dout).
- mem_rdata  output  8  read data returned to the CPU (the CPU's mem_din).
- io_buffer_full  output  1  TX FIFO nearly full.
- ram_addr  output  RAM_ADDR_W  RAM address.
- ram_we  output  1  RAM write enable.
- ram_wdata  output  8  RAM write data.
- ram_rdata  input  8  RAM read data, valid 1 cycle after address.
- rx_valid  input  1  UART RX byte available.
- rx_data  input  8  UART RX byte.
- rx_pop  output  1  consume RX byte this cycle.
- tx_valid  output  1  TX byte available.
- tx_data  output  8  TX byte.
- tx_ready  input  1  UART TX accepts a byte.
- program_stop  output  1  program finished, TX drained.

Behaviour:
- Decode: io_sel = (mem_a[17:16]==2'b11); otherwise RAM. ram_addr = mem_a[RAM_ADDR_W-1:0]. ram_we = mem_wr & ~io_sel. All decode is combinational in the access cycle.
- Read latency: exactly 1 cycle.
  - Registered rd_src (RAM, RX, CNT, ZERO) and rd_byte are captured at the access.
  - mem_rdata is a mux of ram_rdata / rx byte register / counter snapshot byte / 0x00.
- IO read 0x30000:
  - If rx_valid: rx_pop=1 that cycle, byte registered, returned next cycle.
  - Else returns 0x00, no pop.
- IO read 0x30004..0x30007: returns byte mem_a[1:0] of the counter snapshot, little-endian.
  - A read of 0x30004 loads the snapshot from the live counter.
  - Reads of 0x30005–7 use the existing snapshot, so a 4-byte read is coherent.
- Any other IO read returns 0x00.
- IO write 0x30000:
  - Nonzero data pushes to the TX FIFO.
  - 0x00 is ignored.
  - Push while FIFO full (and no pop that cycle) is dropped.
- IO write 0x30004: starts the stop sequence. Other IO writes are ignored.
- TX FIFO:
  - tx_valid = ~empty; tx_data = head entry, stable while tx_valid & ~tx_ready.
  - Push and pop in the same cycle are both honoured, including when full.
  - Pointers wrap modulo TX_DEPTH.
- io_buffer_full: registered, 1 when count >= TX_DEPTH-2. The margin covers the CPU's 1-cycle sampling lag.
- Cycle counter: +1 every cycle while state != HALTED; wraps at 2^CNT_W.
- Stop FSM:
  - RUN --write 0x30004--> PUSH_NUL.
  - PUSH_NUL: push 0x00 (bypasses the zero filter) when the FIFO is not full --> DRAIN.
  - DRAIN: wait for FIFO empty --> HALTED.
  - HALTED: program_stop=1; absorbing until reset.
  - In any state other than RUN, further IO writes are ignored.
- Reset: mem_rdata=0, rx_pop=0, tx_valid=0, io_buffer_full=0, program_stop=0, counter=0, snapshot=0, FIFO empty, state RUN, rd_src ZERO. Reset mid-drain discards FIFO contents.

Optional Feature:
- MEM_IO_DROP_CNT_EN defined:
  - A 16-bit saturating counter of dropped TX pushes is kept.
  - It is readable at 0x30008 (low byte) and 0x30009 (high byte) with the same 1-cycle latency.
  - It is cleared by reset.
- MEM_IO_DROP_CNT_EN undefined: no counter; those addresses read 0x00.

Decomposition:
- Package mem_io_pkg holds:
  - IO_SEL value 2'b11.
  - Offsets IO_UART=0x0, IO_CNT=0x4, IO_DROP=0x8.
  - Enum stop_state_t {RUN, PUSH_NUL, DRAIN, HALTED}.
  - Enum rd_src_t {SRC_RAM, SRC_RX, SRC_CNT, SRC_ZERO, SRC_DROP}.
- One sub-module: mem_io_tx_fifo (parameterised sync FIFO with count output).

Test Plan:
- RAM path: write 0xA5 to 0x00123, then read 0x00123 -> ram_we pulses in the write cycle; mem_rdata=0xA5 one cycle after the read.
- UART TX: writes 0x48, 0x00, 0x69 to 0x30000 with tx_ready=1 -> tx_data sequence 0x48, 0x69 only.
- Backpressure, tx_ready=0, TX_DEPTH=8:
  - 6 writes -> io_buffer_full=1 the cycle after the 6th push.
  - 9 writes -> 8 stored, 9th dropped (drop count=1 with MEM_IO_DROP_CNT_EN).
- Counter coherence: read 0x30004..0x30007 on consecutive cycles starting at counter=0x000000FF -> bytes FF,00,00,00, even though the live counter has passed 0x100.
- RX: rx_valid=1, rx_data=0x7A, read 0x30000 -> rx_pop one cycle, mem_rdata=0x7A; with rx_valid=0 -> 0x00, no pop.
- Stop with 3 bytes queued, tx_ready toggling:
  - Write 0x30004 -> the 3 bytes then 0x00 are transmitted.
  - program_stop rises only after empty; counter frozen thereafter.
  - rst_in low mid-DRAIN -> all outputs 0 immediately.
